// File: rtl/reaction_sequencer.sv
// Reaction-timer game controller: random wait, stimulus LED, then a timed response
// reported as two BCD digits (10 ms units) with a read strobe for the LED decoder.
//
// state | meaning
// IDLE  | waiting for the first start press
// ARMED | random wait running, stimulus not yet shown
// STIM  | stimulus LED on, response time counting
// SHOW  | result held on c/d with read high
module reaction_sequencer #(
    parameter int          TICK_DIV  = 500000,
    parameter int          DELAY_MIN = 100,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk50M,
    input  logic       reset_n,
    input  logic       start,
    input  logic       react,
    output logic [3:0] c,
    output logic [3:0] d,
    output logic       read,
    output logic       stim,
    output logic       false_start,
    output logic       busy
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int WAIT_W  = $clog2(DELAY_MIN + 64);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_STIM, S_SHOW} state_t;

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic                 start_q, react_q;
    logic [3:0]           c_q, c_d, d_q, d_d;
    logic                 fs_q, fs_d;
    logic                 read_q, read_d, stim_q, stim_d, busy_q, busy_d;

    logic                 start_rise, react_rise, tick;
    logic [WAIT_W-1:0]    wait_load;

    assign start_rise = start & ~start_q;
    assign react_rise = react & ~react_q;
    assign tick       = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign wait_load  = WAIT_W'(DELAY_MIN) + WAIT_W'(lfsr_q[5:0]);
    assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        c_d     = c_q;
        d_d     = d_q;
        fs_d    = fs_q;
        case (state_q)
            S_IDLE, S_SHOW: begin
                if (start_rise) begin
                    wait_d  = wait_load;
                    c_d     = 4'd0;
                    d_d     = 4'd0;
                    fs_d    = 1'b0;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                // a press before the stimulus wins even on the expiry cycle
                if (react_rise) begin
                    c_d     = 4'hF;
                    d_d     = 4'hF;
                    fs_d    = 1'b1;
                    state_d = S_SHOW;
                end else if (tick) begin
                    wait_d = wait_q - WAIT_W'(1);
                    if (wait_q <= WAIT_W'(1)) begin
                        c_d     = 4'd0;
                        d_d     = 4'd0;
                        state_d = S_STIM;
                    end
                end
            end
            S_STIM: begin
                if (react_rise) begin
                    state_d = S_SHOW;
                end else if (tick) begin
                    if (d_q == 4'd9 && c_q == 4'd9) begin
                        state_d = S_SHOW;
                    end else if (c_q == 4'd9) begin
                        c_d = 4'd0;
                        d_d = d_q + 4'd1;
                    end else begin
                        c_d = c_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // prescaler restarts on every state entry so ticks are phase-aligned to it
        presc_d = (state_d != state_q || tick) ? '0 : presc_q + PRESC_W'(1);
        read_d  = (state_d == S_SHOW);
        stim_d  = (state_d == S_STIM);
        busy_d  = (state_d == S_ARMED) || (state_d == S_STIM);
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            wait_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            start_q <= 1'b0;
            react_q <= 1'b0;
            c_q     <= 4'd0;
            d_q     <= 4'd0;
            fs_q    <= 1'b0;
            read_q  <= 1'b0;
            stim_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            wait_q  <= wait_d;
            lfsr_q  <= lfsr_d;
            start_q <= start;
            react_q <= react;
            c_q     <= c_d;
            d_q     <= d_d;
            fs_q    <= fs_d;
            read_q  <= read_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
        end
    end

    assign c           = c_q;
    assign d           = d_q;
    assign read        = read_q;
    assign stim        = stim_q;
    assign false_start = fs_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Self-checking bench for reaction_sequencer: cycle-level behavioural model compared
// every negedge, plus directed trials with hand-computed literal expectations.
module tb_reaction_sequencer;

    localparam int TICK_DIV  = 4;
    localparam int DELAY_MIN = 3;

    localparam int P_IDLE = 0, P_ARMED = 1, P_STIM = 2, P_SHOW = 3;

    logic       clk50M  = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic       react   = 1'b0;
    logic [3:0] c, d;
    logic       read, stim, false_start, busy;

    int checks = 0;
    int errors = 0;

    reaction_sequencer #(
        .TICK_DIV (TICK_DIV),
        .DELAY_MIN(DELAY_MIN),
        .LFSR_SEED(8'hA5)
    ) dut (
        .clk50M     (clk50M),
        .reset_n    (reset_n),
        .start      (start),
        .react      (react),
        .c          (c),
        .d          (d),
        .read       (read),
        .stim       (stim),
        .false_start(false_start),
        .busy       (busy)
    );

    always #5 clk50M = ~clk50M;

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h want %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_phase = P_IDLE;
    int       m_cnt   = 0;     // cycles spent in the current phase
    int       m_wait  = 0;     // remaining wait, whole ticks
    int       m_res   = 0;     // response time, 0..99 ticks
    bit       m_ff    = 0;     // result shows FF (false start)
    bit       m_fs    = 0;
    logic [7:0] m_lfsr = 8'hA5;
    bit       m_sp = 0, m_rp = 0;
    bit       sr, rr, tk, newtrial;
    int       nphase;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    always @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = P_IDLE; m_cnt = 0; m_wait = 0; m_res = 0;
            m_ff = 0; m_fs = 0; m_lfsr = 8'hA5; m_sp = 0; m_rp = 0;
        end else begin
            sr = start && !m_sp;
            rr = react && !m_rp;
            tk = (m_cnt % TICK_DIV) == TICK_DIV - 1;
            nphase = m_phase;
            newtrial = 0;
            case (m_phase)
                P_IDLE, P_SHOW: if (sr) newtrial = 1;
                P_ARMED: begin
                    if (rr) begin
                        nphase = P_SHOW; m_fs = 1; m_ff = 1;
                    end else if (tk) begin
                        m_wait = m_wait - 1;
                        if (m_wait == 0) begin nphase = P_STIM; m_res = 0; end
                    end
                end
                P_STIM: begin
                    if (rr) nphase = P_SHOW;
                    else if (tk) begin
                        if (m_res == 99) nphase = P_SHOW;
                        else m_res = m_res + 1;
                    end
                end
                default: nphase = P_IDLE;
            endcase
            if (newtrial) begin
                nphase = P_ARMED;
                m_wait = DELAY_MIN + int'(m_lfsr[5:0]);
                m_res = 0; m_ff = 0; m_fs = 0;
            end
            m_cnt   = (nphase != m_phase) ? 0 : m_cnt + 1;
            m_phase = nphase;
            m_lfsr  = lfsr_next(m_lfsr);
            m_sp    = start;
            m_rp    = react;
        end
    end

    always @(negedge clk50M) begin
        cmp("read",  {7'd0, read},  {7'd0, m_phase == P_SHOW});
        cmp("stim",  {7'd0, stim},  {7'd0, m_phase == P_STIM});
        cmp("busy",  {7'd0, busy},  {7'd0, m_phase == P_ARMED || m_phase == P_STIM});
        cmp("false_start", {7'd0, false_start}, {7'd0, m_fs});
        cmp("c", {4'd0, c}, m_ff ? 8'h0F : 8'(m_res % 10));
        cmp("d", {4'd0, d}, m_ff ? 8'h0F : 8'(m_res / 10));
    end

    // ---------------- directed stimulus ----------------
    task automatic press_start();
        start = 1'b1;
        @(negedge clk50M);
        start = 1'b0;
    endtask

    task automatic wait_stim(input int max_cyc);
        int n = 0;
        while (!stim && n < max_cyc) begin
            @(negedge clk50M);
            n++;
        end
        cmp("stim_timeout", {7'd0, stim}, 8'd1);
    endtask

    int cnt;
    int w;
    logic [3:0] c0, d0;
    bit stable;

    initial begin
        repeat (2) @(negedge clk50M);
        cmp("reset_outs", {c, d}, 8'h00);
        cmp("reset_flags", {4'd0, read, stim, false_start, busy}, 8'h00);
        reset_n = 1'b1;
        repeat (2) @(negedge clk50M);

        // trial 1: lfsr=95 at the start edge -> wait 3+21=24 ticks = 96 cycles
        press_start();
        cmp("model_wait", 8'(m_wait), 8'd24);
        cnt = 0;
        while (busy && !stim && cnt < 300) begin
            cnt++;
            @(negedge clk50M);
        end
        cmp("armed_cycles", 8'(cnt), 8'd96);
        repeat (92) @(negedge clk50M);
        react = 1'b1;
        @(negedge clk50M);
        cmp("rt23_dc", {d, c}, 8'h23);
        cmp("rt23_flags", {4'd0, read, stim, false_start, busy}, 8'b1000);
        c0 = c; d0 = d; stable = 1;
        repeat (50) begin
            @(negedge clk50M);
            if (c !== c0 || d !== d0 || read !== 1'b1) stable = 0;
        end
        cmp("show_hold", {7'd0, stable}, 8'd1);
        react = 1'b0;
        @(negedge clk50M);

        // new trial from SHOW, then false start during ARMED
        start = 1'b1;
        @(negedge clk50M);
        start = 1'b0;
        cmp("restart_read", {6'd0, read, busy}, 8'b01);
        repeat (10) @(negedge clk50M);
        react = 1'b1;
        @(negedge clk50M);
        cmp("fs_dc", {d, c}, 8'hFF);
        cmp("fs_flags", {4'd0, read, stim, false_start, busy}, 8'b1010);
        react = 1'b0;
        @(negedge clk50M);

        // timeout: 100 ticks in STIM, result 99
        press_start();
        wait_stim(400);
        cnt = 0;
        while (stim && cnt < 600) begin
            cnt++;
            @(negedge clk50M);
        end
        cmp("stim_cycles", 8'(cnt / 4), 8'd100);
        cmp("timeout_dc", {d, c}, 8'h99);
        cmp("timeout_read", {7'd0, read}, 8'd1);
        repeat (3) @(negedge clk50M);

        // react coincident with the 5th tick: count stays 4
        press_start();
        wait_stim(400);
        repeat (19) @(negedge clk50M);
        react = 1'b1;
        @(negedge clk50M);
        cmp("tick_react_dc", {d, c}, 8'h04);
        react = 1'b0;
        @(negedge clk50M);

        // react coincident with wait expiry: false start wins
        start = 1'b1;
        @(negedge clk50M);
        start = 1'b0;
        w = m_wait;
        repeat (w * TICK_DIV - 1) @(negedge clk50M);
        react = 1'b1;
        @(negedge clk50M);
        cmp("expiry_fs", {6'd0, false_start, stim}, 8'b10);
        cmp("expiry_dc", {d, c}, 8'hFF);
        react = 1'b0;
        @(negedge clk50M);

        // asynchronous reset mid-STIM
        press_start();
        wait_stim(400);
        repeat (5) @(negedge clk50M);
        @(posedge clk50M);
        #2 reset_n = 1'b0;
        #1;
        cmp("async_rst", {c, d}, 8'h00);
        cmp("async_rst_flags", {4'd0, read, stim, false_start, busy}, 8'h00);
        @(posedge clk50M);
        @(negedge clk50M);
        reset_n = 1'b1;

        // react held high across the start press: no false start
        react = 1'b1;
        repeat (3) @(negedge clk50M);
        press_start();
        cmp("held_react", {6'd0, false_start, busy}, 8'b01);
        wait_stim(400);
        react = 1'b0;
        repeat (6) @(negedge clk50M);
        react = 1'b1;
        @(negedge clk50M);
        cmp("held_dc", {d, c}, 8'h01);
        cmp("held_flags", {4'd0, read, stim, false_start, busy}, 8'b1000);
        react = 1'b0;
        repeat (5) @(negedge clk50M);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_sequencer.md
Name: reaction_sequencer

Overview:
- Game-flow controller for the reaction timer. Sequences one trial: random wait, stimulus LED, timed response.
- Produces a two-digit BCD result (c = units, d = tens, in 10 ms steps) and the read strobe that drives the downstream LED decoder.
- Sits between the debounced push-buttons and the LED decoder, in the clk50M domain.

Parameters:
- TICK_DIV, 500000, clk50M cycles per timing tick (10 ms at 50 MHz); minimum 2.
- DELAY_MIN, 100, minimum random wait in ticks before the stimulus.
- LFSR_SEED, 8'hA5, LFSR value loaded at reset; must be non-zero.

Ports:
- clk50M  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  debounced start button, synchronous to clk50M, active-high level.
- react  in  1  debounced reaction button, synchronous to clk50M, active-high level.
- c  out  4  BCD units digit of the result.
- d  out  4  BCD tens digit of the result.
- read  out  1  result-valid strobe to the LED decoder.
- stim  out  1  stimulus LED.
- false_start  out  1  flags that react was pressed before the stimulus.
- busy  out  1  high in ARMED and STIM.

Behaviour:
- Reset (async assert, sync release): state IDLE; c=0, d=0, read=0, stim=0, false_start=0, busy=0; tick prescaler 0; lfsr=LFSR_SEED; edge registers 0.
- Edge detect: start_rise and react_rise are level AND NOT the previous-cycle registered level. Only rising edges act.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Steps every cycle in every state except during reset.
- Prescaler: counts 0..TICK_DIV-1 and emits a tick on wrap. It is cleared on every state entry, so the first tick comes TICK_DIV cycles after entry.
- IDLE:
  - On start_rise: load wait = DELAY_MIN + lfsr[5:0], clear c, d, read and false_start, then go to ARMED.
- ARMED (busy=1):
  - Each tick decrements wait.
  - When wait reaches 0: go to STIM.
  - react_rise: go to SHOW with c=d=4'hF and false_start=1. react_rise has priority over wait expiry in the same cycle.
  - start_rise is ignored.
- STIM (busy=1, stim=1):
  - On entry, {d,c} = 00.
  - Each tick increments {d,c} as BCD: c wraps 9->0 and carries into d.
  - react_rise: go to SHOW holding the current {d,c}. It has priority over a same-cycle tick, so the tick is not counted.
  - Timeout: a tick with {d,c}=99 goes to SHOW holding 99.
- SHOW (busy=0, stim=0, read=1):
  - read asserts on the first cycle in SHOW and the c/d values are already final in that cycle.
  - c and d are held stable for the whole time read is high.
  - start_rise: read=0, load a new wait, go straight to ARMED (new trial). The decoder clears because read drops for the entire ARMED/STIM period.
  - react_rise is ignored.
- Outputs are registered; no combinational path from any input to any output.
- Reset asserted mid-trial forces IDLE and reset values immediately, regardless of state.
- No illegal-state lockup: any unencoded state value recovers to IDLE on the next clock.

Test Plan (TICK_DIV=4, DELAY_MIN=3, LFSR_SEED=8'hA5 unless noted):
- Reset, then a start pulse -> busy=1 and stim=0 for (3 + lfsr[5:0] captured at the start edge)*4 cycles (±1), then stim=1.
- In STIM, press react after 23 ticks (92 cycles ±3) -> SHOW with d=2, c=3, read=1, stim=0, false_start=0; values hold for 50 cycles.
- Press react during ARMED -> c=4'hF, d=4'hF, false_start=1, read=1, stim never asserted.
- In STIM, never press react -> after 100 ticks {d,c}=99 and read=1; the count never wraps to 00.
- Same-cycle events, via forced timing: react_rise coincident with a tick in STIM -> count not incremented. react_rise coincident with wait expiry -> false start.
- Pulse reset_n low for 1 cycle mid-STIM -> all outputs 0 asynchronously, state IDLE. Also: react held high across a start press -> no react_rise, so no false start. A second start in SHOW -> read falls the next cycle and a new wait begins.
